datapath_seq: RTL
=================

Name: datapath_seq

Overview:
- Parametrised successor to the 16-bit register-file/ALU datapath: configurable word width and register count, N/Z/V status flags, and an internal sequencer.
- Sequencer runs a full read-A, read-B, execute, write-back operation from a single start pulse, so a controller no longer drives loada/loadb/loadc/write cycle by cycle.
- Sits between the instruction controller and the memory/IO input path.

Parameters:
- W, 16, datapath word width (>=4).
- NREG, 8, number of registers (power of two, >=2).
- IMM_W, 5, immediate width; zero-extended to W (IMM_W < W).
- AW is localparam clog2(NREG), not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request an operation; sampled only in IDLE.
- rn  in  AW  A-operand register index.
- rm  in  AW  B-operand register index.
- rd  in  AW  destination register index.
- alu_op  in  2  00 add, 01 sub (A-B), 10 and, 11 not B.
- shift  in  2  applied to B: 00 none, 01 lsl1, 10 lsr1 (zero fill), 11 asr1.
- use_imm  in  1  B operand = zero-extended imm; unshifted.
- a_zero  in  1  A operand forced to 0.
- set_flags  in  1  update status in EXEC.
- wb_en  in  1  write result to rd in WB.
- imm  in  IMM_W  immediate.
- ext_we  in  1  external register write; honoured only in IDLE.
- ext_addr  in  AW  external write index.
- ext_data  in  W  external write data.
- dbg_addr  in  AW  combinational debug read index.
- dbg_data  out  W  R[dbg_addr], combinational.
- result  out  W  C register.
- status  out  3  {N,Z,V} registered.
- busy  out  1  state != IDLE.
- done  out  1  high exactly in the WB cycle.

Behaviour:
- Reset: all registers R[0..NREG-1] = 0; A, B, C = 0; result = 0; status = 000; state = IDLE; busy = 0; done = 0.
- Reset mid-operation aborts the operation with no write-back; reset wins over every other input.
- FSM states: IDLE -> LOADA -> LOADB -> EXEC -> WB -> IDLE.
  - IDLE leaves only on start=1.
  - All other transitions are unconditional.
- Command latch: at the accepting edge, rn, rm, rd, alu_op, shift, use_imm, a_zero, set_flags, wb_en and imm are latched. Input changes during busy have no effect.
- LOADA: A <= R[rn].
- LOADB: B <= R[rm].
- EXEC:
  - Ain = a_zero ? 0 : A.
  - Bin = use_imm ? zext(imm) : shift(B).
  - C <= ALU(Ain, Bin), mod 2^W.
  - If set_flags: Z = (res == 0), N = res[W-1].
  - V for add = Ain[W-1]==Bin[W-1] && res[W-1]!=Ain[W-1].
  - V for sub = Ain[W-1]!=Bin[W-1] && res[W-1]!=Ain[W-1].
  - V = 0 for and/not.
  - If set_flags=0, status holds.
- WB:
  - done = 1.
  - If wb_en: R[rd] <= C at the end of the cycle.
  - result is valid (C) from WB onward and holds until the next EXEC.
- Latency: start accepted at edge k; done is high in cycle k+4; the register write is visible at edge k+5. Minimum issue interval is 5 cycles.
- start while busy is ignored, not queued. start in the WB cycle is ignored.
- ext_we in IDLE writes R[ext_addr] at that edge. ext_we while busy is ignored.
- ext_we and start in the same IDLE cycle: both take effect. A LOADA/LOADB read of ext_addr returns the new value.
- rn == rm == rd is legal: reads use pre-write values, and the write occurs in WB.
- shift on the MSB: lsl1 drops the MSB; asr1 replicates the MSB.
- dbg_data is a pure combinational read and does not see a same-cycle write until after the edge.

Test Plan:
- Reset, then ext-write R1=5, R2=3; start add rd=3 rn=1 rm=2 wb_en set_flags -> done 4 cycles after accept; R3=8; status=000.
- R1=3, R2=3, sub, set_flags -> result 0, status Z=1 N=0 V=0. Same with set_flags=0 -> status unchanged.
- W=16: R1=16'h7FFF, R2=1, add -> 16'h8000, N=1 V=1. R1=16'h8000, R2=1, sub -> 16'h7FFF, V=1.
- R2=16'h8001: shift=11 not-B path gives ~16'hC000 = 16'h3FFF; shift=01 with use_imm=1, imm=5'h1F, a_zero, add -> result 16'h001F (immediate unshifted).
- start pulses during busy plus ext_we while busy -> no extra done, register untouched; ext_we and start together in IDLE -> operand sees new value.
- Assert reset in EXEC with wb_en -> rd unchanged (0), busy=0, done never asserted. Rerun with W=32, NREG=16: add of 32'hFFFFFFFF+1 -> 0, Z=1.

Source files
------------

// File: rtl/datapath_seq_if.sv
// Command/status bus between the instruction controller and datapath_seq.
//   master : controller side; drives the command, external write and debug index.
//   slave  : datapath side; returns debug read, result, {N,Z,V} status, busy, done.
// W / NREG / IMM_W must match the parameters of the attached datapath_seq.
interface datapath_seq_if #(
    parameter int W     = 16,
    parameter int NREG  = 8,
    parameter int IMM_W = 5
);
    localparam int AW = $clog2(NREG);

    logic             start;
    logic [AW-1:0]    rn, rm, rd;
    logic [1:0]       alu_op, shift;
    logic             use_imm, a_zero, set_flags, wb_en;
    logic [IMM_W-1:0] imm;
    logic             ext_we;
    logic [AW-1:0]    ext_addr;
    logic [W-1:0]     ext_data;
    logic [AW-1:0]    dbg_addr;
    logic [W-1:0]     dbg_data;
    logic [W-1:0]     result;
    logic [2:0]       status;
    logic             busy, done;

    modport master (
        output start, rn, rm, rd, alu_op, shift, use_imm, a_zero, set_flags, wb_en, imm,
               ext_we, ext_addr, ext_data, dbg_addr,
        input  dbg_data, result, status, busy, done
    );

    modport slave (
        input  start, rn, rm, rd, alu_op, shift, use_imm, a_zero, set_flags, wb_en, imm,
               ext_we, ext_addr, ext_data, dbg_addr,
        output dbg_data, result, status, busy, done
    );
endinterface

// File: rtl/datapath_seq.sv
// Register-file / ALU datapath with a built-in sequencer.
// One start pulse in IDLE runs LOADA -> LOADB -> EXEC -> WB -> IDLE.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; aborts any operation in flight
//   bus   : datapath_seq_if.slave (command latch, external write, debug read,
//           result = C register, status = {N,Z,V}, busy, done in WB)
module datapath_seq #(
    parameter int W     = 16,
    parameter int NREG  = 8,
    parameter int IMM_W = 5
) (
    input logic         clk,
    input logic         reset,
    datapath_seq_if.slave bus
);
    localparam int AW = $clog2(NREG);

    typedef enum logic [2:0] {IDLE, LOADA, LOADB, EXEC, WB} state_t;

    // Command captured at the accepting edge; inputs are ignored while busy.
    typedef struct packed {
        logic [AW-1:0]    rn, rm, rd;
        logic [1:0]       alu_op, shift;
        logic             use_imm, a_zero, set_flags, wb_en;
        logic [IMM_W-1:0] imm;
    } cmd_t;

    state_t       state;
    cmd_t         cmd;
    logic [W-1:0] regs [NREG];
    logic [W-1:0] a_q, b_q, c_q;
    logic [2:0]   status_q;
    logic         busy_q, done_q;

    logic [W-1:0] b_sh, ain, bin, res;
    logic         v;

    always_comb begin
        ain = cmd.a_zero ? '0 : a_q;
        unique case (cmd.shift)
            2'b01:   b_sh = {b_q[W-2:0], 1'b0};      // lsl1, MSB lost
            2'b10:   b_sh = {1'b0, b_q[W-1:1]};      // lsr1, zero fill
            2'b11:   b_sh = {b_q[W-1], b_q[W-1:1]};  // asr1, sign kept
            default: b_sh = b_q;
        endcase
        // The immediate bypasses the shifter.
        bin = cmd.use_imm ? {{(W-IMM_W){1'b0}}, cmd.imm} : b_sh;
        res = '0;
        v   = 1'b0;
        unique case (cmd.alu_op)
            2'b00: begin
                res = ain + bin;
                v   = (ain[W-1] == bin[W-1]) && (res[W-1] != ain[W-1]);
            end
            2'b01: begin
                res = ain - bin;
                v   = (ain[W-1] != bin[W-1]) && (res[W-1] != ain[W-1]);
            end
            2'b10:   res = ain & bin;
            default: res = ~bin;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cmd      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= 3'b000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // A same-edge start still sees this write: LOADA reads one edge later.
                    if (bus.ext_we) regs[bus.ext_addr] <= bus.ext_data;
                    if (bus.start) begin
                        cmd.rn        <= bus.rn;
                        cmd.rm        <= bus.rm;
                        cmd.rd        <= bus.rd;
                        cmd.alu_op    <= bus.alu_op;
                        cmd.shift     <= bus.shift;
                        cmd.use_imm   <= bus.use_imm;
                        cmd.a_zero    <= bus.a_zero;
                        cmd.set_flags <= bus.set_flags;
                        cmd.wb_en     <= bus.wb_en;
                        cmd.imm       <= bus.imm;
                        state         <= LOADA;
                        busy_q        <= 1'b1;
                    end
                end
                LOADA: begin
                    a_q   <= regs[cmd.rn];
                    state <= LOADB;
                end
                LOADB: begin
                    b_q   <= regs[cmd.rm];
                    state <= EXEC;
                end
                EXEC: begin
                    c_q <= res;
                    if (cmd.set_flags) status_q <= {res[W-1], res == '0, v};
                    done_q <= 1'b1;  // registered so it is high exactly during WB
                    state  <= WB;
                end
                WB: begin
                    if (cmd.wb_en) regs[cmd.rd] <= c_q;
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dbg_data = regs[bus.dbg_addr];
    assign bus.result   = c_q;
    assign bus.status   = status_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule
